// File: rtl/alu_iter_if.sv
// Issue/writeback handshake bundle for alu_iter.
// Master is the issuer and result consumer; slave is the ALU.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, result,
    input  zero, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, result,
    output zero, div_by_zero
  );
endinterface

// File: rtl/alu_iter.sv
// Handshaked ALU with single-cycle ops plus
// iterative shift-add MUL and restoring DIVU.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_iter_if.slave io
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SEQ  = 4'b1000;
  localparam logic [3:0] OP_SNE  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SGT  = 4'b1011;
  localparam logic [3:0] OP_SLE  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_SGE  = 4'b1110;
  localparam logic [3:0] OP_DIVU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   acc_q, opb_q, opq_q;
  logic [WIDTH-1:0]   res_q;
  logic               is_div_q;
  logic               zero_q, dbz_q;

  logic               accept, multi, last;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               set_bit;
  logic [WIDTH:0]     trial, diff;
  logic               fits;
  logic [WIDTH-1:0]   acc_d, opb_d, opq_d;
  logic [WIDTH-1:0]   fin;

  assign io.in_ready = (state_q == IDLE) ||
                       (state_q == DONE && io.out_ready);
  assign accept = io.in_valid && io.in_ready;
  assign multi  = (io.ctrl == OP_MUL) || (io.ctrl == OP_DIVU);
  assign last   = (cnt_q == SHAMT_W'(WIDTH - 1));
  assign shamt  = io.b[SHAMT_W-1:0];

  assign io.out_valid   = (state_q == DONE);
  assign io.result      = res_q;
  assign io.zero        = zero_q;
  assign io.div_by_zero = dbz_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = multi ? BUSY : DONE;
      BUSY: if (last) state_d = DONE;
      DONE: begin
        if (io.out_ready) begin
          if (accept) state_d = multi ? BUSY : DONE;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    set_bit = 1'b0;
    alu_res = '0;
    unique case (io.ctrl)
      OP_ADD: alu_res = io.a + io.b;
      OP_SUB: alu_res = io.a - io.b;
      OP_AND: alu_res = io.a & io.b;
      OP_OR:  alu_res = io.a | io.b;
      OP_SLL: alu_res = io.a << shamt;
      OP_XOR: alu_res = io.a ^ io.b;
      OP_SRA: alu_res = $signed(io.a) >>> shamt;
      OP_SRL: alu_res = io.a >> shamt;
      OP_SEQ: set_bit = (io.a == io.b);
      OP_SNE: set_bit = (io.a != io.b);
      OP_SLT: set_bit = ($signed(io.a) <  $signed(io.b));
      OP_SGT: set_bit = ($signed(io.a) >  $signed(io.b));
      OP_SLE: set_bit = ($signed(io.a) <= $signed(io.b));
      OP_SGE: set_bit = ($signed(io.a) >= $signed(io.b));
      default: alu_res = '0;
    endcase
    if (io.ctrl[3] && io.ctrl != OP_MUL && io.ctrl != OP_DIVU)
      alu_res = {{(WIDTH-1){1'b0}}, set_bit};
  end

  // MUL: acc += mcand per set multiplier bit.
  // DIVU: shift dividend MSB into the remainder and
  // subtract the divisor whenever it fits.
  always_comb begin
    trial = {acc_q, opq_q[WIDTH-1]};
    diff  = trial - {1'b0, opb_q};
    fits  = ~diff[WIDTH];
    acc_d = acc_q;
    opb_d = opb_q;
    opq_d = opq_q;
    if (is_div_q) begin
      acc_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      opq_d = {opq_q[WIDTH-2:0], fits};
      fin   = opq_d;
    end else begin
      acc_d = opq_q[0] ? acc_q + opb_q : acc_q;
      opb_d = opb_q << 1;
      opq_d = opq_q >> 1;
      fin   = acc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      opq_q    <= '0;
      res_q    <= '0;
      is_div_q <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= '0;
        is_div_q <= (io.ctrl == OP_DIVU);
        if (multi) begin
          acc_q  <= '0;
          opb_q  <= (io.ctrl == OP_DIVU) ? io.b : io.a;
          opq_q  <= (io.ctrl == OP_DIVU) ? io.a : io.b;
          zero_q <= 1'b0;
          dbz_q  <= 1'b0;
        end else begin
          res_q  <= alu_res;
          zero_q <= (alu_res == '0);
          dbz_q  <= 1'b0;
        end
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + SHAMT_W'(1);
        acc_q <= acc_d;
        opb_q <= opb_d;
        opq_q <= opq_d;
        if (last) begin
          res_q  <= fin;
          zero_q <= (fin == '0);
          dbz_q  <= is_div_q && (opb_q == '0);
        end
      end else if (state_q == DONE && io.out_ready) begin
        zero_q <= 1'b0;
        dbz_q  <= 1'b0;
      end
    end
  end

endmodule
